rv32i_regfile_clr: RTL and testbench
====================================

# rv32i_regfile_clr

Two-read, one-write RV32I integer register file with registered read ports, same-edge write-to-read bypass and a hardware clear sequencer. After reset it zeroes r1–r31, then asserts `ready`. It is the responder for the register-file request interface (`rs1/rs2/rd/renb1/renb2/wenb/wdata`) driven by the decode/writeback stages and by the module-level random bench. Storage is flop/LUT-RAM without per-entry reset, so the clear is performed sequentially.

## Interface
- `XLEN`, 32, data width.
- `CLR_ON_RESET`, 1, 1 = run the clear sequence after reset; 0 = go straight to READY with contents undefined except r0.
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `rs1`  in  5  first source register address.
- `rs2`  in  5  second source register address.
- `rd`  in  5  destination register address.
- `renb1`  in  1  read enable, port 1.
- `renb2`  in  1  read enable, port 2.
- `wenb`  in  1  write enable.
- `wdata`  in  XLEN  write data.
- `rdata1`  out  XLEN  registered read data, port 1.
- `rdata2`  out  XLEN  registered read data, port 2.
- `ready`  out  1  1 = clear done; requests are accepted.

## Operation
- States: CLEAR, READY. The reset value is CLEAR with `clr_idx`=1, or READY when `CLR_ON_RESET`=0.
- CLEAR:
  - Each edge writes 0 to `regs[clr_idx]`, then increments `clr_idx`.
  - At `clr_idx`=31 the write happens and the state becomes READY.
  - All request inputs are ignored. `rdata1/2` hold 0.
- READY:
  - `wenb`=1 and `rd`≠0: write `wdata` to `regs[rd]` at the edge.
  - `renb1`=1: `rdata1` loads the port-1 read value at the edge. `renb1`=0: `rdata1` holds its previous value. Port 2 behaves the same with `renb2`/`rs2`.
  - Read value = 0 if the address is 0. Otherwise it is `wdata` if `wenb` and `rd` equals the address (bypass). Otherwise it is `regs[addr]`.
- r0 is hardwired to 0. Writes to r0 are discarded and never bypassed.
- Both ports may read the same register, including the one being written; both return the bypassed value.
- `reset` low at any time, including mid-clear:
  - asynchronously forces the state to CLEAR, `clr_idx`=1, `rdata1/2`=0, `ready`=0;
  - the clear restarts from r1 after release;
  - the array itself is not asynchronously reset.

## Timing
- Reset values: `rdata1`=0, `rdata2`=0, `ready`=0 (`ready`=1 when `CLR_ON_RESET`=0).
- Clear duration: exactly 31 rising edges after reset release. `ready` goes 1 after the 31st edge. A request sampled on the first edge where `ready` is already 1 is honoured.
- Read latency: 1 cycle. Inputs are sampled at edge N, and `rdata` is valid from edge N until the next loading edge.
- Write visibility:
  - at the write edge itself, via the bypass;
  - via the array from edge N+1 onward.
- No stall or backpressure exists after `ready`. One request is accepted per cycle.

## Structure
- Package `regfile_pkg` holds:
  - `XLEN_DEF`=32, `REG_ADDR_W`=5, `NUM_REGS`=32, `CLR_LAST`=5'd31;
  - the state enum `rf_state_t` {CLEAR, READY}.
- Sub-module `regfile_clr_seq` contains the state register, `clr_idx` counter and `ready`. It outputs the internal write mux controls (`clr_we`, `clr_addr`). The top level owns the array, the bypass and the read registers.
- The internal write port is a single mux: the sequencer in CLEAR, the external port in READY.

## Test plan
- Release reset, hold `renb1`=1, `rs1`=17 → `ready`=1 exactly 31 edges after release. `rdata1`=0 on the first READY read.
- READY: write r5=0xDEADBEEF, next cycle read `rs1`=5 → `rdata1`=0xDEADBEEF one cycle later. `rdata2` is unchanged with `renb2`=0.
- Same edge: `wenb`=1, `rd`=7, `wdata`=0x12345678, `rs1`=`rs2`=7, both enables set → both `rdata` outputs = 0x12345678 after that edge.
- Write r0=0xFFFFFFFF, then read `rs1`=0 and `rs2`=0, including the same-edge case → both 0.
- Assert `reset` low 10 edges into the clear for 2 cycles:
  - `rdata`=0 and `ready`=0 immediately;
  - `ready` returns 31 edges after the second release;
  - an r9 value written before the reset reads back 0.
- 10000 random READY cycles compared against the one-cycle-delayed combinational reference regfile → zero mismatches.

Source files
------------

// File: rtl/rv32i_regfile_clr_pkg.sv
// Shared definitions for the RV32I register file with hardware clear.
//   XLEN_DEF   : default data width
//   REG_ADDR_W : register address width
//   NUM_REGS   : architectural register count (r0 included)
//   CLR_LAST   : last register index written by the clear sequence
//   rf_state_t : clear sequencer state
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] CLR_LAST = 5'd31;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rv32i_regfile_clr_seq.sv
// Clear sequencer for the register file. After reset it walks clr_idx from
// r1 to r31, requesting a zero write to each entry, then raises ready.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   CLEAR | zeroing regs[clr_idx] on every edge; external requests ignored
//   READY | clear complete; external port owns the array write port
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   ready    out  1 = clear complete
//   clr_we   out  internal write enable for the clear write
//   clr_addr out  register index being cleared
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    output logic                  clr_we,
    output logic [REG_ADDR_W-1:0] clr_addr
);

    localparam rf_state_t RESET_STATE = CLR_ON_RESET ? CLEAR : READY;

    rf_state_t             state;
    rf_state_t             state_nxt;
    logic [REG_ADDR_W-1:0] clr_idx;
    logic [REG_ADDR_W-1:0] clr_idx_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RESET_STATE;
            clr_idx <= REG_ADDR_W'(1);
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        clr_we      = 1'b0;
        clr_addr    = clr_idx;
        ready       = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                // The write to r31 and the switch to READY share one edge,
                // so the whole clear takes exactly 31 edges.
                if (clr_idx == CLR_LAST) begin
                    state_nxt = READY;
                end else begin
                    clr_idx_nxt = clr_idx + REG_ADDR_W'(1);
                end
            end
            READY: begin
                ready = 1'b1;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_regfile_clr.sv
// Two-read, one-write RV32I integer register file with registered read
// ports, same-edge write-to-read bypass and a post-reset clear of r1..r31.
// The array has no per-entry reset; the clear sequencer zeroes it instead.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   rs1, rs2     in   source register addresses
//   rd           in   destination register address
//   renb1, renb2 in   read enables; a disabled port holds its last value
//   wenb         in   write enable
//   wdata        in   write data
//   rdata1/2     out  registered read data
//   ready        out  1 = clear complete, requests accepted
module rv32i_regfile_clr
    import regfile_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  renb1,
    input  logic                  renb2,
    input  logic                  wenb,
    input  logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       rdata1,
    output logic [XLEN-1:0]       rdata2,
    output logic                  ready
);

    // r0 has no storage; it is hardwired to zero on the read side.
    logic [XLEN-1:0] regs [1:NUM_REGS-1];

    logic                  clr_we;
    logic [REG_ADDR_W-1:0] clr_addr;

    logic                  ext_we;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic [XLEN-1:0]       rd_val1;
    logic [XLEN-1:0]       rd_val2;

    regfile_clr_seq #(
        .CLR_ON_RESET (CLR_ON_RESET)
    ) u_clr_seq (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Writes to r0 never reach the array and never feed the bypass.
    assign ext_we = wenb && (rd != '0);

    // Single array write port: the sequencer owns it until ready.
    always_comb begin
        wr_en   = clr_we;
        wr_addr = clr_addr;
        wr_data = '0;
        if (ready) begin
            wr_en   = ext_we;
            wr_addr = rd;
            wr_data = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_val1 = '0;
        if (rs1 != '0) begin
            if (ext_we && (rd == rs1)) begin
                rd_val1 = wdata;
            end else begin
                rd_val1 = regs[rs1];
            end
        end
    end

    always_comb begin
        rd_val2 = '0;
        if (rs2 != '0) begin
            if (ext_we && (rd == rs2)) begin
                rd_val2 = wdata;
            end else begin
                rd_val2 = regs[rs2];
            end
        end
    end

    // Read registers only load once the clear is done, so they stay at
    // their reset value of zero throughout the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else if (ready) begin
            if (renb1) begin
                rdata1 <= rd_val1;
            end
            if (renb2) begin
                rdata2 <= rd_val2;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_regfile_clr.sv
module tb_rv32i_regfile_clr;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        renb1;
    logic        renb2;
    logic        wenb;
    logic [31:0] wdata;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        ready;

    int n_checks;
    int n_fail;

    rv32i_regfile_clr #(
        .XLEN         (32),
        .CLR_ON_RESET (1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd     (rd),
        .renb1  (renb1),
        .renb2  (renb2),
        .wenb   (wenb),
        .wdata  (wdata),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .ready  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one edge; outputs are sampled and inputs changed 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int edges);
        edges = 0;
        while (!ready && edges < 200) begin
            tick();
            edges++;
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] d, input logic [31:0] wd,
                         input logic e1, input logic [4:0] a1,
                         input logic e2, input logic [4:0] a2);
        wenb  = we;
        rd    = d;
        wdata = wd;
        renb1 = e1;
        rs1   = a1;
        renb2 = e2;
        rs2   = a2;
    endtask

    logic [31:0] ref_regs [0:31];
    logic [31:0] exp1;
    logic [31:0] exp2;
    int          edges;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Reset state
        tick();
        tick();
        check("reset_rdata1", rdata1, 32'h0);
        check("reset_rdata2", rdata2, 32'h0);
        check("reset_ready", {31'b0, ready}, 32'h0);

        // Clear takes 31 edges; a request held through it is served once ready
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd17, 1'b0, 5'd0);
        wait_ready(edges);
        check("clear_edges", edges, 32'd31);
        tick();
        check("first_read_r17", rdata1, 32'h0);

        // Bypass on port 2 gives it a known non-zero value
        drive(1'b1, 5'd6, 32'h0BADF00D, 1'b0, 5'd0, 1'b1, 5'd6);
        tick();
        check("bypass_r6_rdata2", rdata2, 32'h0BADF00D);

        // Write r5 with both reads disabled: outputs hold
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 1'b0, 5'd5);
        tick();
        check("hold_rdata1", rdata1, 32'h0);
        check("hold_rdata2", rdata2, 32'h0BADF00D);

        // Read r5 from the array on port 1, port 2 still disabled
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5);
        tick();
        check("read_r5", rdata1, 32'hDEADBEEF);
        check("rdata2_unchanged", rdata2, 32'h0BADF00D);

        // Same-edge write and read on both ports
        drive(1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b1, 5'd7);
        tick();
        check("same_edge_rdata1", rdata1, 32'h12345678);
        check("same_edge_rdata2", rdata2, 32'h12345678);

        // Write to r0 with same-edge reads of r0: no bypass
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        tick();
        check("r0_same_edge_rdata1", rdata1, 32'h0);
        check("r0_same_edge_rdata2", rdata2, 32'h0);

        // r7 from the array, r0 still zero after the discarded write
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd0);
        tick();
        check("read_r7_array", rdata1, 32'h12345678);
        check("r0_after_write", rdata2, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd6);
        tick();
        check("r0_port1", rdata1, 32'h0);
        check("read_r6_array", rdata2, 32'h0BADF00D);

        // Write r9, read it back on both ports
        drive(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);
        tick();
        check("read_r9", rdata1, 32'hA5A5A5A5);
        check("read_r9_p2", rdata2, 32'hA5A5A5A5);

        // Asynchronous reset from READY clears outputs without an edge
        reset = 1'b0;
        #1;
        check("async_rdata1", rdata1, 32'h0);
        check("async_rdata2", rdata2, 32'h0);
        check("async_ready", {31'b0, ready}, 32'h0);
        tick();
        reset = 1'b1;
        // Requests during the clear must be ignored
        drive(1'b1, 5'd9, 32'h5A5A5A5A, 1'b1, 5'd9, 1'b1, 5'd5);
        for (int i = 0; i < 10; i++) tick();
        check("mid_clear_ready", {31'b0, ready}, 32'h0);
        check("mid_clear_rdata1", rdata1, 32'h0);

        // Reset 10 edges into the clear, held for 2 cycles
        reset = 1'b0;
        #1;
        check("mid_reset_ready", {31'b0, ready}, 32'h0);
        check("mid_reset_rdata2", rdata2, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd5);
        wait_ready(edges);
        check("reclear_edges", edges, 32'd31);
        tick();
        check("r9_cleared", rdata1, 32'h0);
        check("r5_cleared", rdata2, 32'h0);

        // Random READY traffic against a behavioural reference
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        exp1 = 32'h0;
        exp2 = 32'h0;
        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) rs2 = rs1;
            if ($urandom_range(0, 3) == 0) rd = rs1;
            if (renb1) exp1 = (rs1 == 5'd0) ? 32'h0 :
                              (wenb && rd == rs1) ? wdata : ref_regs[rs1];
            if (renb2) exp2 = (rs2 == 5'd0) ? 32'h0 :
                              (wenb && rd == rs2) ? wdata : ref_regs[rs2];
            if (wenb && rd != 5'd0) ref_regs[rd] = wdata;
            tick();
            check("rand_rdata1", rdata1, exp1);
            check("rand_rdata2", rdata2, exp2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
